// File: rtl/fft_pkg.sv
// Shared constants, twiddle tables and helpers for the iterative 8-point DIF inverse FFT.
package fft_pkg;
  localparam int N        = 8;
  localparam int DW       = 16;
  localparam int FRAC     = 12;
  localparam int BF_TOTAL = 12;
  localparam logic signed [DW-1:0] TW_C45 = 16'sh0B50;

  // W8^-k = cos(2*pi*k/8) + j*sin(2*pi*k/8), k = 0..3, Q4.12
  localparam logic signed [DW-1:0] TW_RE [4] = '{16'sh1000, 16'sh0B50, 16'sh0000, 16'shF4B0};
  localparam logic signed [DW-1:0] TW_IM [4] = '{16'sh0000, 16'sh0B50, 16'sh1000, 16'sh0B50};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [2*DW:0] v);
    if (v > 33'sd32767) return 16'sh7FFF;
    if (v < -33'sd32768) return 16'sh8000;
    return v[DW-1:0];
  endfunction
endpackage

// File: rtl/fft_bfly_dif.sv
// Combinational radix-2 DIF butterfly: s = (a+b)/2, b' = ((a-b)/2) * W8^-tw_idx.
module fft_bfly_dif
  import fft_pkg::*;
(
  input  logic [2*DW-1:0] a_i,
  input  logic [2*DW-1:0] b_i,
  input  logic [1:0]      tw_idx_i,
  output logic [2*DW-1:0] s_o,
  output logic [2*DW-1:0] d_o
);
  logic signed [DW-1:0]   ar, ai, br, bi, dr, di, c, sn, wr, wi;
  logic signed [DW:0]     sum_re, sum_im, dif_re, dif_im;
  logic signed [2*DW-1:0] p_rc, p_is, p_rs, p_ic;
  logic signed [2*DW:0]   acc_re, acc_im, rnd_re, rnd_im;

  always_comb begin
    ar = a_i[2*DW-1:DW];
    ai = a_i[DW-1:0];
    br = b_i[2*DW-1:DW];
    bi = b_i[DW-1:0];
    // 17-bit sum/difference halved by dropping the LSB: never overflows 16 bits
    sum_re = (DW+1)'(ar) + (DW+1)'(br);
    sum_im = (DW+1)'(ai) + (DW+1)'(bi);
    dif_re = (DW+1)'(ar) - (DW+1)'(br);
    dif_im = (DW+1)'(ai) - (DW+1)'(bi);
    dr = dif_re[DW:1];
    di = dif_im[DW:1];
    c  = TW_RE[tw_idx_i];
    sn = TW_IM[tw_idx_i];
    p_rc = dr * c;
    p_is = di * sn;
    p_rs = dr * sn;
    p_ic = di * c;
    acc_re = (2*DW+1)'(p_rc) - (2*DW+1)'(p_is) + 33'sd2048;
    acc_im = (2*DW+1)'(p_rs) + (2*DW+1)'(p_ic) + 33'sd2048;
    rnd_re = acc_re >>> FRAC;
    rnd_im = acc_im >>> FRAC;
    wr = dr;
    wi = di;
    case (tw_idx_i)
      2'd0: begin
        wr = dr;
        wi = di;
      end
      2'd2: begin
        wr = (di == 16'sh8000) ? 16'sh7FFF : -di;
        wi = dr;
      end
      default: begin
        wr = sat_dw(rnd_re);
        wi = sat_dw(rnd_im);
      end
    endcase
    s_o = {sum_re[DW:1], sum_im[DW:1]};
    d_o = {wr, wi};
  end
endmodule

// File: rtl/dif_ifft_8_iter.sv
// Iterative 8-point DIF inverse FFT: one shared butterfly runs 3 stages x 4 butterflies
// over an 8-entry register file; result is 1/8-scaled and returned in natural order.
module dif_ifft_8_iter
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*2*DW-1:0] x_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*2*DW-1:0] y_flat
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid holds its payload stable until that edge, ready never depends on valid.
  state_e          state_q;
  logic [3:0]      bf_cnt_q;
  logic [2*DW-1:0] mem_q [N];
  logic            in_ready_q, out_valid_q;
  logic [2:0]      idx_a, idx_b;
  logic [1:0]      tw_idx, j;
  logic [2*DW-1:0] bf_s, bf_d;

  always_comb begin
    j      = bf_cnt_q[1:0];
    idx_a  = '0;
    idx_b  = '0;
    tw_idx = '0;
    case (bf_cnt_q[3:2])
      2'd0: begin
        idx_a  = {1'b0, j};
        idx_b  = {1'b1, j};
        tw_idx = j;
      end
      2'd1: begin
        idx_a  = {j[1], 1'b0, j[0]};
        idx_b  = {j[1], 1'b1, j[0]};
        tw_idx = {j[0], 1'b0};
      end
      2'd2: begin
        idx_a  = {j, 1'b0};
        idx_b  = {j, 1'b1};
        tw_idx = 2'd0;
      end
      default: ;
    endcase
  end

  fft_bfly_dif u_bfly (
    .a_i      (mem_q[idx_a]),
    .b_i      (mem_q[idx_b]),
    .tw_idx_i (tw_idx),
    .s_o      (bf_s),
    .d_o      (bf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bf_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            for (int k = 0; k < N; k++) mem_q[k] <= x_flat[32*k +: 32];
            bf_cnt_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          // bf_cnt = 12 is a settle cycle after the last butterfly
          if (bf_cnt_q == 4'(BF_TOTAL)) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            mem_q[idx_a] <= bf_s;
            mem_q[idx_b] <= bf_d;
            bf_cnt_q     <= bf_cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    y_flat = '0;
    for (int n = 0; n < N; n++)
      if (state_q == ST_DONE) y_flat[32*n +: 32] = mem_q[bitrev3(3'(n))];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_dif_ifft_8_iter.sv
// Directed and round-trip bench for dif_ifft_8_iter with hand-computed expected frames.
module tb_dif_ifft_8_iter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [255:0] x_flat = '0;
  logic [255:0] y_flat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    int           tol;
  } vec_t;

  vec_t vecs [5];

  dif_ifft_8_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_flat    (y_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cpx(input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    return {r, i};
  endfunction

  function automatic logic [255:0] fill(input logic [31:0] v);
    logic [255:0] f;
    for (int n = 0; n < 8; n++) f[32*n +: 32] = v;
    return f;
  endfunction

  // Unscaled forward DFT in floating point, as a forward FFT would deliver it
  function automatic logic [255:0] fwd_dft(input logic [255:0] x);
    logic [255:0]        f;
    logic signed [15:0]  xr, xi;
    real                 acc_re, acc_im, th;
    for (int k = 0; k < 8; k++) begin
      acc_re = 0.0;
      acc_im = 0.0;
      for (int n = 0; n < 8; n++) begin
        xr = x[32*n+16 +: 16];
        xi = x[32*n +: 16];
        th = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        acc_re = acc_re + real'(int'(xr)) * $cos(th) + real'(int'(xi)) * $sin(th);
        acc_im = acc_im + real'(int'(xi)) * $cos(th) - real'(int'(xr)) * $sin(th);
      end
      f[32*k +: 32] = cpx(int'(acc_re), int'(acc_im));
    end
    return f;
  endfunction

  task automatic check_word(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [255:0] exp, input int tol);
    logic signed [15:0] ar, ai, er, ei;
    int dr, di;
    for (int n = 0; n < 8; n++) begin
      ar = y_flat[32*n+16 +: 16];
      ai = y_flat[32*n +: 16];
      er = exp[32*n+16 +: 16];
      ei = exp[32*n +: 16];
      dr = int'(ar) - int'(er);
      di = int'(ai) - int'(ei);
      n_checks++;
      if (dr > tol || dr < -tol || di > tol || di < -tol) begin
        n_fail++;
        $display("FAIL %s y[%0d]: got %h+j%h, expected %h+j%h (tol %0d)", tag, n, ar, ai, er, ei, tol);
      end
    end
  endtask

  task automatic send_frame(input string tag, input logic [255:0] x, output bit ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = in_ready;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s in_ready timeout: got 0, expected 1", tag);
      return;
    end
    x_flat   = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_word({tag, " out_valid after consume"}, 256'(out_valid), 256'(0));
    check_word({tag, " in_ready after consume"}, 256'(in_ready), 256'(1));
  endtask

  task automatic run_frame(input string tag, input logic [255:0] x, input logic [255:0] exp, input int tol);
    bit ok;
    int lat;
    send_frame(tag, x, ok);
    if (!ok) return;
    wait_out(lat);
    check_word({tag, " latency"}, 256'(lat), 256'(13));
    if (!out_valid) return;
    check_frame(tag, exp, tol);
    consume(tag);
  endtask

  initial begin
    logic [255:0] snap, xr, imp_x, imp_y;
    int re, im;

    imp_x = '0;
    imp_x[31:0] = cpx(16'h1000, 0);
    imp_y = fill(cpx(16'h0200, 0));

    // impulse
    vecs[0].x = imp_x;
    vecs[0].y = imp_y;
    vecs[0].tol = 0;
    // DC
    vecs[1].x = fill(cpx(16'h1000, 0));
    vecs[1].y = '0;
    vecs[1].y[31:0] = cpx(16'h1000, 0);
    vecs[1].tol = 1;
    // bin 1: 0x200 * e^{j*2*pi*n/8}, 0x200*cos(pi/4) = 362
    vecs[2].x = '0;
    vecs[2].x[63:32] = cpx(16'h1000, 0);
    vecs[2].y = {cpx(362, -362), cpx(0, -512), cpx(-362, -362), cpx(-512, 0),
                 cpx(-362, 362), cpx(0, 512), cpx(362, 362), cpx(512, 0)};
    vecs[2].tol = 1;
    // bin 2: 0x200 * e^{j*pi*n/2}
    vecs[3].x = '0;
    vecs[3].x[95:64] = cpx(16'h1000, 0);
    vecs[3].y = {cpx(0, -512), cpx(-512, 0), cpx(0, 512), cpx(512, 0),
                 cpx(0, -512), cpx(-512, 0), cpx(0, 512), cpx(512, 0)};
    vecs[3].tol = 1;
    // most negative full scale: halving per stage must not wrap
    vecs[4].x = fill(32'h8000_8000);
    vecs[4].y = '0;
    vecs[4].y[31:0] = 32'h8000_8000;
    vecs[4].tol = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_word("reset in_ready", 256'(in_ready), 256'(0));
    check_word("reset out_valid", 256'(out_valid), 256'(0));
    check_word("reset y_flat", y_flat, 256'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check_word("in_ready after reset", 256'(in_ready), 256'(1));

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].tol);

    // backpressure: output held, extra frames ignored
    begin
      bit ok;
      int lat;
      send_frame("bp", imp_x, ok);
      if (ok) begin
        wait_out(lat);
        check_word("bp latency", 256'(lat), 256'(13));
        check_frame("bp", imp_y, 0);
        snap = y_flat;
        for (int c = 0; c < 20; c++) begin
          x_flat   = vecs[1].x;
          in_valid = c[0];
          @(posedge clk); #1;
          check_word("bp y_flat stable", y_flat, snap);
          check_word("bp in_ready low", 256'(in_ready), 256'(0));
          check_word("bp out_valid held", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        consume("bp");
        for (int c = 0; c < 16; c++) begin
          @(posedge clk); #1;
          check_word("bp no extra frame", 256'(out_valid), 256'(0));
        end
      end
    end

    // reset while bf_cnt = 6
    begin
      bit ok;
      send_frame("midreset", vecs[2].x, ok);
      if (ok) begin
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_word("midreset out_valid", 256'(out_valid), 256'(0));
        check_word("midreset y_flat", y_flat, 256'(0));
        check_word("midreset in_ready", 256'(in_ready), 256'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check_word("midreset in_ready after", 256'(in_ready), 256'(1));
        for (int c = 0; c < 14; c++) begin
          @(posedge clk); #1;
          check_word("midreset no stale output", 256'(out_valid), 256'(0));
        end
        run_frame("post-reset impulse", imp_x, imp_y, 0);
      end
    end

    // round trip from forward-DFT spectra of random frames
    for (int f = 0; f < 2; f++) begin
      xr = '0;
      for (int n = 0; n < 8; n++) begin
        re = int'($urandom_range(0, 2048)) - 1024;
        im = int'($urandom_range(0, 2048)) - 1024;
        xr[32*n +: 32] = cpx(re, im);
      end
      run_frame($sformatf("roundtrip%0d", f), fwd_dft(xr), xr, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
